// File: rtl/lampfpu_issue_queue.sv
// lampfpu_issue_queue: request FIFO plus a one-outstanding-op sequencer in front of lampFPU_top.
// Requests are issued as single-cycle opcode pulses and answered in order over a valid/ready port.
module lampfpu_issue_queue #(
  parameter int DEPTH     = 4,
  parameter int OPCODE_DW = 4,
  parameter int RND_DW    = 2,
  parameter int INT_DW    = 32,
  parameter int FLT_DW    = 16,
  parameter int TAG_DW    = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush_i,
  input  logic                     req_valid_i,
  output logic                     req_ready_o,
  input  logic [OPCODE_DW-1:0]     req_opcode_i,
  input  logic [RND_DW-1:0]        req_rnd_i,
  input  logic [INT_DW-1:0]        req_op1_i,
  input  logic [FLT_DW-1:0]        req_op2_i,
  input  logic [TAG_DW-1:0]        req_tag_i,
  output logic                     fpu_flush_o,
  output logic                     fpu_padv_o,
  output logic [OPCODE_DW-1:0]     fpu_opcode_o,
  output logic [RND_DW-1:0]        fpu_rnd_o,
  output logic [INT_DW-1:0]        fpu_op1_o,
  output logic [FLT_DW-1:0]        fpu_op2_o,
  input  logic [INT_DW-1:0]        fpu_result_i,
  input  logic                     fpu_valid_i,
  input  logic                     fpu_ready_i,
  output logic                     rsp_valid_o,
  input  logic                     rsp_ready_i,
  output logic [INT_DW-1:0]        rsp_result_o,
  output logic [TAG_DW-1:0]        rsp_tag_o,
  output logic [$clog2(DEPTH):0]   count_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int EW = OPCODE_DW + RND_DW + INT_DW + FLT_DW + TAG_DW;
  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;
  state_t                state_q;
  logic [EW-1:0]         mem_q [DEPTH];
  logic [AW-1:0]         wr_q, rd_q;
  logic [CW-1:0]         count_q, count_d;
  logic [OPCODE_DW-1:0]  opcode_q, h_opcode;
  logic [RND_DW-1:0]     rnd_q, h_rnd;
  logic [INT_DW-1:0]     op1_q, h_op1, result_q;
  logic [FLT_DW-1:0]     op2_q, h_op2;
  logic [TAG_DW-1:0]     tag_q, h_tag;
  logic                  rsp_valid_q, push, pop;
  assign {h_opcode, h_rnd, h_op1, h_op2, h_tag} = mem_q[rd_q];
  // No bypass: a full queue refuses even when a pop happens in the same cycle.
  assign req_ready_o = rst && count_q < CW'(DEPTH) && !flush_i;
  assign push        = req_valid_i && req_ready_o;
  assign pop         = state_q == S_IDLE && count_q != '0 && fpu_ready_i && !flush_i;
  assign count_d     = push && !pop ? count_q + 1'b1 : pop && !push ? count_q - 1'b1 : count_q;
  always_ff @(posedge clk)
    if (push) mem_q[wr_q] <= {req_opcode_i, req_rnd_i, req_op1_i, req_op2_i, req_tag_i};
  always_ff @(posedge clk)
    if (!rst || flush_i) begin
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
    end else begin
      wr_q    <= wr_q + AW'(push);
      rd_q    <= rd_q + AW'(pop);
      count_q <= count_d;
    end
  always_ff @(posedge clk)
    if (!rst) begin
      state_q     <= S_IDLE;
      opcode_q    <= '0;
      rnd_q       <= '0;
      op1_q       <= '0;
      op2_q       <= '0;
      tag_q       <= '0;
      result_q    <= '0;
      rsp_valid_q <= 1'b0;
    end else if (flush_i) begin
      state_q     <= S_IDLE;
      opcode_q    <= '0;
      rsp_valid_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE:
          if (pop) begin
            state_q  <= S_ISSUE;
            opcode_q <= h_opcode;
            rnd_q    <= h_rnd;
            op1_q    <= h_op1;
            op2_q    <= h_op2;
            tag_q    <= h_tag;
          end
        S_ISSUE: begin
          opcode_q <= '0;
          state_q  <= S_WAIT;
        end
        S_WAIT:
          if (fpu_valid_i) begin
            result_q    <= fpu_result_i;
            rsp_valid_q <= 1'b1;
            state_q     <= S_RESP;
          end
        S_RESP:
          if (rsp_ready_i) begin
            rsp_valid_q <= 1'b0;
            state_q     <= S_IDLE;
          end
        default: state_q <= S_IDLE;
      endcase
    end
  assign fpu_flush_o  = flush_i;
  assign fpu_padv_o   = rst;
  assign fpu_opcode_o = opcode_q;
  assign fpu_rnd_o    = rnd_q;
  assign fpu_op1_o    = op1_q;
  assign fpu_op2_o    = op2_q;
  assign rsp_valid_o  = rsp_valid_q;
  assign rsp_result_o = result_q;
  assign rsp_tag_o    = tag_q;
  assign count_o      = count_q;
endmodule

// File: tb/tb_lampfpu_issue_queue.sv
// tb_lampfpu_issue_queue: directed and random checks of the issue queue against a
// scoreboard of expected responses and a behavioural FPU with configurable latency.
`timescale 1ns/1ps
module tb_lampfpu_issue_queue;
  logic        clk, rst, flush_i, req_valid_i, req_ready_o;
  logic [3:0]  req_opcode_i, req_tag_i, fpu_opcode_o, rsp_tag_o;
  logic [1:0]  req_rnd_i, fpu_rnd_o;
  logic [31:0] req_op1_i, fpu_op1_o, fpu_result_i, rsp_result_o;
  logic [15:0] req_op2_i, fpu_op2_o;
  logic        fpu_flush_o, fpu_padv_o, fpu_valid_i, fpu_ready_i, rsp_valid_o, rsp_ready_i;
  logic [2:0]  count_o;
  int          checks = 0, errors = 0, fpu_lat = 1;
  logic        pushed, man_valid;
  logic [31:0] man_res;
  logic [3:0]  exp_tag[$];
  logic [31:0] exp_res[$];

  lampfpu_issue_queue dut (
    .clk(clk), .rst(rst), .flush_i(flush_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_opcode_i(req_opcode_i),
    .req_rnd_i(req_rnd_i), .req_op1_i(req_op1_i), .req_op2_i(req_op2_i), .req_tag_i(req_tag_i),
    .fpu_flush_o(fpu_flush_o), .fpu_padv_o(fpu_padv_o), .fpu_opcode_o(fpu_opcode_o),
    .fpu_rnd_o(fpu_rnd_o), .fpu_op1_o(fpu_op1_o), .fpu_op2_o(fpu_op2_o),
    .fpu_result_i(fpu_result_i), .fpu_valid_i(fpu_valid_i), .fpu_ready_i(fpu_ready_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_result_o(rsp_result_o),
    .rsp_tag_o(rsp_tag_o), .count_o(count_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stand-in FPU arithmetic: opcode 1 on equal operands 0x3F80 yields 0x4000.
  function automatic logic [31:0] fpu_fn(input logic [3:0] op, input logic [31:0] a, input logic [15:0] b);
    return (a ^ {16'h0, b}) + ({28'h0, op} << 14);
  endfunction

  // Behavioural FPU: sees a nonzero opcode pulse and answers fpu_lat+1 cycles later.
  initial begin : fpu_model
    int cnt;
    logic [31:0] pend;
    cnt = -1;
    pend = '0;
    fpu_valid_i = 1'b0;
    fpu_result_i = '0;
    forever begin
      @(posedge clk);
      #2;
      fpu_valid_i = 1'b0;
      if (cnt == 0) begin
        fpu_valid_i = 1'b1;
        fpu_result_i = pend;
        cnt = -1;
      end else if (cnt > 0) cnt--;
      if (fpu_opcode_o != 4'h0) begin
        pend = fpu_fn(fpu_opcode_o, fpu_op1_o, fpu_op2_o);
        cnt = fpu_lat;
      end
      if (man_valid) begin
        fpu_valid_i = 1'b1;
        fpu_result_i = man_res;
      end
    end
  end

  task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
    end
  endtask

  // Resolve this cycle's handshakes against the scoreboard, then advance one clock.
  task automatic tick();
    #3;
    if (req_valid_i && req_ready_o) begin
      exp_tag.push_back(req_tag_i);
      exp_res.push_back(fpu_fn(req_opcode_i, req_op1_i, req_op2_i));
      pushed = 1'b1;
    end
    if (rsp_valid_o && rsp_ready_i && !flush_i && rst) begin
      if (exp_tag.size() == 0) check("rsp_unexpected", rsp_valid_o, 0);
      else begin
        check("rsp_result", rsp_result_o, exp_res.pop_front());
        check("rsp_tag", rsp_tag_o, exp_tag.pop_front());
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [3:0] op, input logic [31:0] a, input logic [15:0] b, input logic [3:0] t);
    req_valid_i = 1'b1;
    req_opcode_i = op;
    req_rnd_i = 2'($urandom);
    req_op1_i = a;
    req_op2_i = b;
    req_tag_i = t;
    pushed = 1'b0;
    for (int i = 0; i < 50 && !pushed; i++) tick();
    check("push_accept", pushed, 1);
    req_valid_i = 1'b0;
  endtask

  task automatic wait_rsp();
    for (int i = 0; i < 100 && !rsp_valid_o; i++) tick();
    check("rsp_timeout", rsp_valid_o, 1);
  endtask

  task automatic drain();
    rsp_ready_i = 1'b1;
    for (int i = 0; i < 300 && exp_tag.size() != 0; i++) tick();
    check("drain_empty", exp_tag.size(), 0);
  endtask

  initial begin
    logic [3:0] nt, op;
    logic saw;
    rst = 1'b0; flush_i = 1'b0; req_valid_i = 1'b0; req_opcode_i = '0; req_rnd_i = '0;
    req_op1_i = '0; req_op2_i = '0; req_tag_i = '0; fpu_ready_i = 1'b1; rsp_ready_i = 1'b0;
    man_valid = 1'b0; man_res = '0; pushed = 1'b0;
    tick(); tick();
    check("rst_req_ready", req_ready_o, 0);
    check("rst_padv", fpu_padv_o, 0);
    check("rst_opcode", fpu_opcode_o, 0);
    check("rst_op1", fpu_op1_o, 0);
    check("rst_op2", fpu_op2_o, 0);
    check("rst_rnd", fpu_rnd_o, 0);
    check("rst_rsp_valid", rsp_valid_o, 0);
    check("rst_rsp_result", rsp_result_o, 0);
    check("rst_rsp_tag", rsp_tag_o, 0);
    check("rst_count", count_o, 0);
    check("rst_fpu_flush", fpu_flush_o, 0);
    rst = 1'b1;
    tick();
    check("post_rst_ready", req_ready_o, 1);
    check("post_rst_padv", fpu_padv_o, 1);

    // Single op with exact cycle timing.
    fpu_lat = 2;
    rsp_ready_i = 1'b1;
    push(4'h1, 32'h3F80, 16'h3F80, 4'h3);
    check("single_count", count_o, 1);
    check("single_no_early_op", fpu_opcode_o, 0);
    tick();
    check("single_pulse", fpu_opcode_o, 1);
    check("single_op1", fpu_op1_o, 32'h3F80);
    check("single_op2", fpu_op2_o, 16'h3F80);
    check("single_rnd", fpu_rnd_o, req_rnd_i);
    tick();
    check("single_pulse_end", fpu_opcode_o, 0);
    check("single_op1_hold", fpu_op1_o, 32'h3F80);
    tick(); tick();
    check("single_not_yet", rsp_valid_o, 0);
    tick();
    check("single_rsp_valid", rsp_valid_o, 1);
    check("single_result", rsp_result_o, 32'h4000);
    check("single_tag", rsp_tag_o, 3);
    tick();
    check("single_rsp_clear", rsp_valid_o, 0);
    check("single_sb_empty", exp_tag.size(), 0);

    // Fill: fifth push fills the queue because the first entry is already popped.
    fpu_lat = 1;
    rsp_ready_i = 1'b0;
    for (int i = 0; i < 5; i++) push(4'($urandom_range(1, 15)), $urandom, 16'($urandom), 4'(i));
    check("fill_count", count_o, 4);
    check("fill_ready", req_ready_o, 0);
    req_valid_i = 1'b1; req_tag_i = 4'hF; pushed = 1'b0;
    tick();
    req_valid_i = 1'b0;
    check("fill_refused", pushed, 0);
    check("fill_count_hold", count_o, 4);
    drain();

    // Backpressure in RESP.
    rsp_ready_i = 1'b0;
    push(4'h5, $urandom, 16'($urandom), 4'h5);
    push(4'h6, $urandom, 16'($urandom), 4'h6);
    wait_rsp();
    for (int i = 0; i < 10; i++) begin
      tick();
      check("bp_valid", rsp_valid_o, 1);
      check("bp_result", rsp_result_o, exp_res[0]);
      check("bp_tag", rsp_tag_o, exp_tag[0]);
      check("bp_no_pulse", fpu_opcode_o, 0);
    end
    rsp_ready_i = 1'b1;
    tick();
    saw = 1'b0;
    for (int i = 0; i < 2 && !saw; i++) begin
      tick();
      saw = fpu_opcode_o == 4'h6;
    end
    check("bp_reissue", saw, 1);
    drain();

    // Flush while waiting on the FPU with three entries still queued.
    fpu_lat = 8;
    rsp_ready_i = 1'b1;
    for (int i = 0; i < 4; i++) push(4'($urandom_range(1, 15)), $urandom, 16'($urandom), 4'(8 + i));
    check("flush_pre_count", count_o, 3);
    flush_i = 1'b1;
    #1;
    check("flush_passthru", fpu_flush_o, 1);
    check("flush_ready", req_ready_o, 0);
    tick();
    flush_i = 1'b0;
    exp_tag.delete();
    exp_res.delete();
    check("flush_count", count_o, 0);
    check("flush_rsp", rsp_valid_o, 0);
    check("flush_opcode", fpu_opcode_o, 0);
    check("flush_fpu_flush_low", fpu_flush_o, 0);
    for (int i = 0; i < 15; i++) begin
      tick();
      check("flush_late_valid", rsp_valid_o, 0);
    end

    // FPU not ready holds the head in the queue.
    fpu_lat = 1;
    fpu_ready_i = 1'b0;
    push(4'h9, $urandom, 16'($urandom), 4'h1);
    for (int i = 0; i < 4; i++) tick();
    check("nready_count", count_o, 1);
    check("nready_no_pulse", fpu_opcode_o, 0);
    fpu_ready_i = 1'b1;
    tick();
    check("nready_issue", fpu_opcode_o, 9);
    drain();

    // Opcode 0 still costs a round trip; the valid is delivered by hand.
    push(4'h0, $urandom, 16'($urandom), 4'h9);
    for (int i = 0; i < 6; i++) tick();
    check("idleop_count", count_o, 0);
    check("idleop_waiting", rsp_valid_o, 0);
    man_res = exp_res[0];
    man_valid = 1'b1;
    tick();
    man_valid = 1'b0;
    check("idleop_rsp", rsp_valid_o, 1);
    drain();

    // Reset in WAIT with two entries queued.
    fpu_lat = 8;
    for (int i = 0; i < 3; i++) push(4'($urandom_range(1, 15)), $urandom, 16'($urandom), 4'(i));
    check("rstw_pre_count", count_o, 2);
    rst = 1'b0;
    tick();
    check("rstw_count", count_o, 0);
    check("rstw_ready", req_ready_o, 0);
    check("rstw_padv", fpu_padv_o, 0);
    check("rstw_op1", fpu_op1_o, 0);
    check("rstw_rsp_tag", rsp_tag_o, 0);
    rst = 1'b1;
    exp_tag.delete();
    exp_res.delete();
    for (int i = 0; i < 15; i++) begin
      tick();
      check("rstw_no_rsp", rsp_valid_o, 0);
    end
    check("rstw_ready_after", req_ready_o, 1);

    // Random traffic against the scoreboard.
    nt = '0;
    for (int i = 0; i < 400; i++) begin
      op = 4'($urandom_range(1, 15));
      req_valid_i = 1'($urandom);
      req_opcode_i = op;
      req_rnd_i = 2'($urandom);
      req_op1_i = $urandom;
      req_op2_i = 16'($urandom);
      req_tag_i = nt;
      rsp_ready_i = 1'($urandom);
      fpu_ready_i = $urandom_range(0, 3) != 0;
      fpu_lat = $urandom_range(0, 4);
      pushed = 1'b0;
      tick();
      if (pushed) nt = nt + 4'h1;
    end
    req_valid_i = 1'b0;
    fpu_ready_i = 1'b1;
    drain();
    check("final_count", count_o, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
